// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Holds the PC, fetches one instruction word at a time over a valid
// handshake, registers it for decode and computes the next PC
// (sequential, PC-relative branch/JAL, register-relative JALR).
// Build option: define FETCH_TRAP_EN to compile in misaligned-target
// detection and the sticky TRAP state; otherwise targets are word-aligned
// by clearing bits [1:0] and trap stays 0.
//
// Handshake: imem_req is high in FETCH and stays high with imem_addr stable
// until imem_valid is sampled high on a rising edge; that edge captures
// imem_rdata. imem_valid is ignored in every other state. Downstream
// consumes instr on any rising edge in ISSUE with stall low.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        stall,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   output logic        trap,
   output logic [31:0] fetch_count,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_ISSUE = 2'd1,
      S_TRAP  = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_instr_valid;
   logic        r_trap;
   logic [31:0] r_count;

   logic        w_consume;
   logic [31:0] w_target;
   logic [31:0] w_new_pc;
   logic        w_misaligned;

   // Next-PC target selection; all additions wrap at 32 bits.
   always_comb begin
      w_target = r_pc + 32'd4;
      case (pc_sel)
         2'b01:   w_target = r_pc + imm;
         2'b10:   w_target = (rs1_data + imm) & 32'hFFFF_FFFE;
         default: w_target = r_pc + 32'd4;
      endcase
   end

   assign w_consume = (r_state == S_ISSUE) && !stall;

`ifdef FETCH_TRAP_EN
   assign w_misaligned = (w_target[1:0] != 2'b00);
   assign w_new_pc     = w_target;
`else
   assign w_misaligned = 1'b0;
   assign w_new_pc     = w_target & 32'hFFFF_FFFC;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_state_next;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH: if (imem_valid) w_state_next = S_ISSUE;
         S_ISSUE: begin
            if (w_consume) w_state_next = w_misaligned ? S_TRAP : S_FETCH;
         end
         S_TRAP:  w_state_next = S_TRAP;
         default: w_state_next = S_FETCH;
      endcase
   end

   // PC, instruction register, trap flag and consume counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_instr       <= NOP;
         r_instr_valid <= 1'b0;
         r_trap        <= 1'b0;
         r_count       <= 32'd0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (imem_valid) begin
                  r_instr       <= imem_rdata;
                  r_instr_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (w_consume) begin
                  r_instr_valid <= 1'b0;
                  if (w_misaligned) begin
                     r_trap <= 1'b1;
                  end else begin
                     r_pc    <= w_new_pc;
                     r_count <= r_count + 32'd1;
                  end
               end
            end
            default: r_instr_valid <= 1'b0;
         endcase
      end
   end

   assign imem_req    = (r_state == S_FETCH) && !rst;
   assign imem_addr   = r_pc;
   assign pc_out      = r_pc;
   assign pc_plus4    = r_pc + 32'd4;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign trap        = r_trap;
   assign fetch_count = r_count;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by a randomized run of
// fetch_unit, every cycle compared against a behavioural model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        stall;
   logic [1:0]  pc_sel;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        trap;
   logic [31:0] fetch_count;
   logic [1:0]  dbg_state;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
      .pc_plus4    (pc_plus4),
      .stall       (stall),
      .pc_sel      (pc_sel),
      .imm         (imm),
      .rs1_data    (rs1_data),
      .trap        (trap),
      .fetch_count (fetch_count),
      .dbg_state   (dbg_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the instruction held, whether it awaits consumption,
   // the PC, the sticky trap flag and the count of consumed instructions.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_count;
   logic        m_valid;
   logic        m_trap;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic exp_req;
      exp_req = !rst && !m_valid && !m_trap;
      chk("imem_req",    {31'd0, imem_req},    {31'd0, exp_req});
      chk("imem_addr",   imem_addr,            m_pc);
      chk("pc_out",      pc_out,               m_pc);
      chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
      chk("instr",       instr,                m_instr);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("trap",        {31'd0, trap},        {31'd0, m_trap});
      chk("fetch_count", fetch_count,          m_count);
   endtask

   // One clock cycle: apply inputs, advance the model, check at the negedge.
   task automatic step(input logic r, input logic v, input logic s,
                       input logic [1:0] sel, input logic [31:0] im,
                       input logic [31:0] rs, input logic [31:0] rd);
      logic [31:0] n_pc, n_instr, n_count, tgt;
      logic        n_valid, n_trap;
      rst = r; imem_valid = v; stall = s; pc_sel = sel;
      imm = im; rs1_data = rs; imem_rdata = rd;
      n_pc = m_pc; n_instr = m_instr; n_count = m_count;
      n_valid = m_valid; n_trap = m_trap;
      if (r) begin
         n_pc = RESET_PC; n_instr = 32'h0000_0013; n_count = 0;
         n_valid = 1'b0; n_trap = 1'b0;
      end else if (m_trap) begin
         n_valid = 1'b0;
      end else if (!m_valid) begin
         if (v) begin n_instr = rd; n_valid = 1'b1; end
      end else if (!s) begin
         if (sel == 2'd1)      tgt = m_pc + im;
         else if (sel == 2'd2) tgt = (rs + im) & 32'hFFFF_FFFE;
         else                  tgt = m_pc + 32'd4;
         n_valid = 1'b0;
`ifdef FETCH_TRAP_EN
         if (tgt % 4 != 0) n_trap = 1'b1;
         else begin n_pc = tgt; n_count = m_count + 1; end
`else
         n_pc = tgt - (tgt % 4);
         n_count = m_count + 1;
`endif
      end
      @(posedge clk);
      m_pc = n_pc; m_instr = n_instr; m_count = n_count;
      m_valid = n_valid; m_trap = n_trap;
      @(negedge clk);
      check_all();
   endtask

   // Fetch with zero wait, then consume with the given redirect.
   task automatic fetch_consume(input logic [1:0] sel, input logic [31:0] im,
                                input logic [31:0] rs, input logic [31:0] rd);
      step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, rd);
      step(1'b0, 1'b1, 1'b0, sel, im, rs, 32'hDEAD_BEEF);
   endtask

   initial begin
      rst = 1'b1; imem_valid = 1'b0; stall = 1'b0; pc_sel = 2'd0;
      imm = 32'd0; rs1_data = 32'd0; imem_rdata = 32'd0;

      // Reset.
      step(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'h1111_1111);
      step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      chk("reset_instr", instr, 32'h0000_0013);
      chk("reset_req", {31'd0, imem_req}, 32'd0);

      // Sequential zero-wait fetch; imem_valid during ISSUE is ignored.
      step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, RESET_PC);
      for (int i = 0; i < 3; i++) fetch_consume(2'd0, 32'd0, 32'd0, 32'h0000_0013);
      chk("seq_count", fetch_count, 32'd3);
      chk("seq_addr", imem_addr, 32'h0000_000C);

      // Wait states at 0x10.
      fetch_consume(2'd0, 32'd0, 32'd0, 32'h0000_0013);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'hBAD0_0000);
         chk("wait_addr", imem_addr, 32'h0000_0010);
      end
      step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'h0050_0093);
      chk("wait_valid", {31'd0, instr_valid}, 32'd1);
      chk("wait_instr", instr, 32'h0050_0093);

      // Stall for 5 cycles, then release with pc+4.
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0040, 32'd0, 32'hFFFF_FFFF);
      chk("stall_pc", pc_out, 32'h0000_0010);
      chk("stall_count", fetch_count, 32'd4);
      step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      chk("release_addr", imem_addr, 32'h0000_0014);

      // Branch and JALR redirect.
      fetch_consume(2'd2, 32'd0, 32'h0000_0100, 32'h0000_0067);
      chk("jalr_to_100", imem_addr, 32'h0000_0100);
      fetch_consume(2'd1, 32'hFFFF_FFF0, 32'd0, 32'h0000_0063);
      chk("branch_back", imem_addr, 32'h0000_00F0);
      fetch_consume(2'd2, 32'h0000_0003, 32'h0000_0205, 32'h0000_0067);
      chk("jalr_clear_lsb", imem_addr, 32'h0000_0208);

      // Reset in FETCH together with imem_valid.
      step(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'h1234_5678);
      chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
      chk("midrst_pc", pc_out, RESET_PC);
      chk("midrst_count", fetch_count, 32'd0);
      step(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);

      // Misaligned branch target from 0x40.
      fetch_consume(2'd2, 32'd0, 32'h0000_0040, 32'h0000_0067);
      fetch_consume(2'd1, 32'h0000_0006, 32'd0, 32'h0000_0063);
`ifdef FETCH_TRAP_EN
      chk("mis_trap", {31'd0, trap}, 32'd1);
      chk("mis_pc", pc_out, 32'h0000_0040);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'hAAAA_AAAA);
      chk("mis_req", {31'd0, imem_req}, 32'd0);
`else
      chk("mis_addr", imem_addr, 32'h0000_0044);
      chk("mis_trap", {31'd0, trap}, 32'd0);
`endif

      // Randomized run.
      step(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r_imm, r_rs1;
         r_imm = $urandom();
         r_rs1 = $urandom();
         if ($urandom_range(7) != 0) r_imm = r_imm & 32'hFFFF_FFFC;
         if ($urandom_range(7) != 0) r_rs1 = r_rs1 & 32'hFFFF_FFFC;
         step(($urandom_range(49) == 0), ($urandom_range(1) == 1),
              ($urandom_range(2) == 0), 2'($urandom_range(3)),
              r_imm, r_rs1, $urandom());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Holds the program counter, requests instruction words from instruction memory over a valid handshake, and registers the fetched word for the decode/immediate-generation stage. Computes the next PC from the immediate returned by that stage: sequential, PC-relative branch/JAL, or register-relative JALR. Issues one instruction at a time, with no speculation.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  word address presented to instruction memory; equals pc_out.
- imem_req  out  1  fetch request; high in FETCH state and low while rst is high.
- imem_rdata  in  32  instruction word from memory.
- imem_valid  in  1  imem_rdata valid this cycle; sampled only in FETCH.
- instr  out  32  registered instruction for decode/immediate generation.
- instr_valid  out  1  instr is current and awaiting consumption.
- pc_out  out  32  PC of the instruction in instr; also the fetch address.
- pc_plus4  out  32  pc_out + 4, for link-register writeback.
- stall  in  1  downstream not ready; instr is held.
- pc_sel  in  2  next-PC select, sampled at consume: 00 = pc+4, 01 = pc+imm (branch taken/JAL), 10 = (rs1_data+imm) & ~1 (JALR), 11 = pc+4.
- imm  in  32  sign-extended immediate for the current instr.
- rs1_data  in  32  rs1 register value for JALR.
- trap  out  1  misaligned fetch target detected; sticky until reset.
- fetch_count  out  32  number of instructions consumed since reset.

## Operation
- Reset values: pc_out = RESET_PC; instr = 32'h0000_0013 (NOP); instr_valid = 0; trap = 0; fetch_count = 0; state = FETCH; imem_req = 0 while rst is high.
- The state machine has three states: FETCH, ISSUE and TRAP.
- FETCH:
  - imem_req = 1 and imem_addr = pc_out; both are held constant until imem_valid.
  - On imem_valid: instr <= imem_rdata, instr_valid <= 1, go to ISSUE.
- ISSUE:
  - instr_valid = 1.
  - If stall = 1: hold all state.
  - If stall = 0: this is a consume.
    - Compute target per pc_sel using 32-bit wrap-around addition; carries are discarded.
    - If the target is aligned: pc_out <= target, instr_valid <= 0, fetch_count += 1 (wraps at 2^32), go to FETCH.
    - If target[1:0] != 0: trap <= 1, instr_valid <= 0, pc_out is unchanged, go to TRAP.
- TRAP: imem_req = 0, instr_valid = 0; exit only through rst.
- imem_valid outside FETCH is ignored.
- pc_sel, imm and rs1_data are sampled only on the consume cycle.
- rst mid-operation: every register returns to its reset value on that edge, and any pending memory response is discarded.
- imem_valid together with rst: rst wins.

## Timing
- Fetch latency: instr_valid rises on the cycle after imem_valid is sampled high in FETCH.
- With zero-wait memory (imem_valid high in the same cycle as imem_req), one instruction takes 2 cycles: FETCH, then ISSUE.
- New imem_addr appears on the cycle after the consume.
- pc_plus4 is combinational from pc_out.
- trap asserts on the cycle after the offending consume.
- The first imem_req after reset appears in the first cycle with rst low, at addr RESET_PC.

## Configuration
- FETCH_TRAP_EN defined: misalignment detection and the TRAP state are compiled in, as described above.
- FETCH_TRAP_EN undefined:
  - target[1:0] is forced to 2'b00 before loading pc_out.
  - trap is tied to 0 and TRAP is unreachable.

## Test plan
- Reset and sequential fetch, zero-wait memory returning 32'h0000_0013, stall = 0, pc_sel = 00:
  - imem_addr sequence 0x0, 0x4, 0x8, one fetch every 2 cycles.
  - fetch_count = 3 after 6 cycles.
- Wait states: imem_valid delayed 3 cycles at pc 0x10.
  - imem_req and imem_addr = 0x10 are held for 4 cycles.
  - instr_valid rises on the cycle after imem_valid.
- Stall: stall = 1 for 5 cycles in ISSUE.
  - instr, pc_out and fetch_count are unchanged.
  - On release with pc_sel = 00, the next imem_addr = pc + 4.
- Branch and JALR redirect:
  - pc = 0x100, pc_sel = 01, imm = 32'hFFFF_FFF0 -> next addr 0x0F0.
  - Then pc_sel = 10, rs1_data = 0x205, imm = 0x3 -> next addr 0x208.
- Misaligned target: pc = 0x40, pc_sel = 01, imm = 0x6.
  - With FETCH_TRAP_EN: trap = 1, imem_req stays 0, pc_out = 0x40.
  - Without FETCH_TRAP_EN: next addr 0x44.
- Reset mid-fetch: rst asserted in FETCH together with imem_valid.
  - Next cycle: instr_valid = 0, pc_out = RESET_PC, fetch_count = 0, trap = 0.
